opcode_fetch: RTL
=================

// Module: opcode_fetch
// PURPOSE
//  Instruction-fetch stage upstream of prime_decoder: loads the reset vector, then fetches the opcode plus 0-2 operand bytes.
//  Presents each complete instruction (opcode, operands, PC) to decode with a valid/ready handshake.
//  Takes PC redirects from execute (branch/jump/interrupt).
// PARAMETERS
//  ADDR_W     16        address bus / PC width
//  RESET_VEC  16'hFFFC  address of the reset vector low byte; high byte is at RESET_VEC+1
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  mem_addr       out  ADDR_W  byte read address
//  mem_rd         out  1       read request; mem_addr is held stable while mem_rd=1 and mem_ready=0
//  mem_rdata      in   8       read data, valid when mem_ready=1
//  mem_ready      in   1       read completes this cycle
//  redirect_valid in   1       load redirect_pc; 1-cycle pulse
//  redirect_pc    in   ADDR_W  new fetch PC
//  inst_valid     out  1       instruction bundle valid
//  inst_ready     in   1       decode accepts the bundle
//  inst_op        out  8       opcode
//  inst_lo        out  8       operand byte 1 (0 if absent)
//  inst_hi        out  8       operand byte 2 (0 if absent)
//  inst_len       out  2       1..3
//  inst_pc        out  ADDR_W  address of the opcode
// BEHAVIOUR
//  Reset values: all outputs 0, pc=0, state=S_VLO. First cycle after reset release: mem_rd=1.
//  FSM:
//   - S_VLO: read RESET_VEC -> pc[7:0].
//   - S_VHI: read RESET_VEC+1 -> pc[15:8].
//   - S_OP: read pc -> inst_op, inst_pc=pc, len=op_len_lut(op), pc+=1; next S_OPR1 if len>1, else S_HOLD.
//   - S_OPR1: read pc -> inst_lo, pc+=1; next S_OPR2 if len==3, else S_HOLD.
//   - S_OPR2: read pc -> inst_hi, pc+=1; next S_HOLD.
//   - S_HOLD: inst_valid=1, bundle stable, mem_rd=0; on inst_ready go to S_OP.
//  Each state advances only on mem_ready. Zero-wait memory gives 1 cycle per byte.
//  inst_valid rises the cycle after the last byte is accepted; an L-byte instruction takes L+1 cycles to acceptance.
//  PC arithmetic is modulo 2^ADDR_W: FFFF+1 wraps to 0000, and operand fetch continues at 0000.
//  Redirect: highest priority, legal in every state except S_VLO/S_VHI, where it is ignored.
//   - Effects: pc<=redirect_pc; state<=S_OP; inst_valid<=0; any partial bundle discarded.
//   - Also discarded: a mem_ready arriving in the same cycle as the redirect.
//   - inst_valid && inst_ready && redirect_valid in one cycle: the handshake completes and the redirect still applies.
//  Operands not fetched are cleared to 0 when a new opcode is captured.
//  op_len_lut (cc=op[1:0], bbb=op[4:2]):
//   - 00/20/40/60 -> 1/3/1/1. Branches xxx10000 -> 2.
//   - cc=01: bbb 011/110/111 -> 3, else 2.
//   - cc=00|10: bbb 000 -> 2 (except above), 001/101 -> 2, 011/111 -> 3, 010/110 -> 1.
//   - cc=11 -> 1 (illegal).
//  rst mid-fetch: immediately returns to reset values; vector fetch restarts.
// CONFIGURATION
//  OPCODE_FETCH_PERF_EN defined:
//   - Adds outputs perf_cycles[31:0] (increments every cycle after reset) and perf_insts[31:0] (increments per accepted bundle).
//   - Both wrap and both reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package core_pkg:
//   - fetch state enum.
//   - Constants OP_BRK=8'h00, OP_JSR=8'h20, OP_RTI=8'h40, OP_RTS=8'h60, BRANCH_MASK/BRANCH_PAT.
//   - Default RESET_VEC.
//  Sub-module op_len_lut: combinational opcode -> 2-bit length; reused by decode.
// TESTING
//  1. Reset, vector at FFFC/FFFD = 00/80 -> first opcode read at 8000; mem_addr sequence FFFC,FFFD,8000.
//  2. Bytes A9 05 (LDA #) at 8000 -> op=A9, lo=05, hi=00, len=2, pc=8000; next fetch at 8002.
//  3. AD 34 12 at FFFE (wraps) -> operands read at FFFF and 0000; bundle AD/34/12, len=3.
//  4. mem_ready low 3 cycles on operand read -> mem_addr/mem_rd held stable; bundle correct; inst_valid delayed 3 cycles.
//  5. inst_ready low 5 cycles -> bundle stable, no reads; redirect to 9000 during hold -> inst_valid=0 next cycle; read 9000.
//  6. redirect_valid coincident with mem_ready in S_OPR1 -> byte discarded; next mem_addr=redirect_pc; no bundle emitted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch state encoding, special opcodes, reset vector.
package core_pkg;

  localparam int unsigned FETCH_STATE_W = 3;
  typedef logic [FETCH_STATE_W-1:0] fetch_state_t;

  // Fetch states
  localparam fetch_state_t S_VLO  = 3'd0;
  localparam fetch_state_t S_VHI  = 3'd1;
  localparam fetch_state_t S_OP   = 3'd2;
  localparam fetch_state_t S_OPR1 = 3'd3;
  localparam fetch_state_t S_OPR2 = 3'd4;
  localparam fetch_state_t S_HOLD = 3'd5;

  // Opcodes whose length does not follow the cc/bbb grouping
  localparam logic [7:0] OP_BRK = 8'h00;
  localparam logic [7:0] OP_JSR = 8'h20;
  localparam logic [7:0] OP_RTI = 8'h40;
  localparam logic [7:0] OP_RTS = 8'h60;

  // Conditional branches: xxx10000
  localparam logic [7:0] BRANCH_MASK = 8'h1F;
  localparam logic [7:0] BRANCH_PAT  = 8'h10;

  localparam logic [15:0] DEFAULT_RESET_VEC = 16'hFFFC;

endpackage

// File: rtl/op_len_lut.sv
// Opcode -> instruction length (1..3 bytes). Shared with the decoder.
module op_len_lut
  import core_pkg::*;
(
  input  logic [7:0] op,
  output logic [1:0] len_c
);

  logic [2:0] bbb;
  assign bbb = op[4:2];

  // Length lookup: special opcodes, then branches, then cc/bbb groups.
  // cc=10 with bbb=100 has no defined addressing mode and is treated as 1 byte.
  always_comb begin
    len_c = 2'd1;
    if (op == OP_JSR) begin
      len_c = 2'd3;
    end else if (op == OP_BRK || op == OP_RTI || op == OP_RTS) begin
      len_c = 2'd1;
    end else if ((op & BRANCH_MASK) == BRANCH_PAT) begin
      len_c = 2'd2;
    end else begin
      case (op[1:0])
        2'b01: begin
          if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len_c = 2'd3;
          else                                                 len_c = 2'd2;
        end
        2'b11: len_c = 2'd1;
        default: begin
          case (bbb)
            3'b000, 3'b001, 3'b101: len_c = 2'd2;
            3'b011, 3'b111:         len_c = 2'd3;
            default:                len_c = 2'd1;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/opcode_fetch.sv
// Instruction fetch: reset vector load, opcode + operand fetch, bundle handshake
// to decode, PC redirect from execute.
// Optional: OPCODE_FETCH_PERF_EN adds perf_cycles / perf_insts counters.
module opcode_fetch
  import core_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]   RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        inst_op,
  output logic [7:0]        inst_lo,
  output logic [7:0]        inst_hi,
  output logic [1:0]        inst_len,
  output logic [ADDR_W-1:0] inst_pc
`ifdef OPCODE_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_insts
`endif
);

  localparam logic [ADDR_W-1:0] VEC_HI_ADDR = RESET_VEC + ADDR_W'(1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, vec_pc;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_rd_nxt, inst_valid_nxt, rd_done;
  logic [7:0]        inst_op_nxt, inst_lo_nxt, inst_hi_nxt;
  logic [1:0]        inst_len_nxt, op_len;
  logic [ADDR_W-1:0] inst_pc_nxt;

  assign rd_done = mem_rd & mem_ready;
  assign pc_inc  = pc + ADDR_W'(1);
  assign vec_pc  = {(ADDR_W-8)'(mem_rdata), pc[7:0]};

  op_len_lut u_len (
    .op    (mem_rdata),
    .len_c (op_len)
  );

  // Next-state, next-PC and next-output logic; redirect overrides everything
  // outside the vector fetch, including a read completing in the same cycle.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    mem_addr_nxt   = mem_addr;
    mem_rd_nxt     = mem_rd;
    inst_valid_nxt = inst_valid;
    inst_op_nxt    = inst_op;
    inst_lo_nxt    = inst_lo;
    inst_hi_nxt    = inst_hi;
    inst_len_nxt   = inst_len;
    inst_pc_nxt    = inst_pc;

    if (redirect_valid && state != S_VLO && state != S_VHI) begin
      state_nxt      = S_OP;
      pc_nxt         = redirect_pc;
      mem_addr_nxt   = redirect_pc;
      mem_rd_nxt     = 1'b1;
      inst_valid_nxt = 1'b0;
    end else begin
      case (state)
        S_VLO: begin
          mem_rd_nxt   = 1'b1;
          mem_addr_nxt = RESET_VEC;
          if (rd_done) begin
            pc_nxt[7:0]  = mem_rdata;
            state_nxt    = S_VHI;
            mem_addr_nxt = VEC_HI_ADDR;
          end
        end
        S_VHI: begin
          if (rd_done) begin
            pc_nxt       = vec_pc;
            mem_addr_nxt = vec_pc;
            state_nxt    = S_OP;
          end
        end
        S_OP: begin
          if (rd_done) begin
            inst_op_nxt  = mem_rdata;
            inst_lo_nxt  = 8'h00;
            inst_hi_nxt  = 8'h00;
            inst_len_nxt = op_len;
            inst_pc_nxt  = pc;
            pc_nxt       = pc_inc;
            if (op_len > 2'd1) begin
              state_nxt    = S_OPR1;
              mem_addr_nxt = pc_inc;
            end else begin
              state_nxt      = S_HOLD;
              mem_rd_nxt     = 1'b0;
              inst_valid_nxt = 1'b1;
            end
          end
        end
        S_OPR1: begin
          if (rd_done) begin
            inst_lo_nxt = mem_rdata;
            pc_nxt      = pc_inc;
            if (inst_len == 2'd3) begin
              state_nxt    = S_OPR2;
              mem_addr_nxt = pc_inc;
            end else begin
              state_nxt      = S_HOLD;
              mem_rd_nxt     = 1'b0;
              inst_valid_nxt = 1'b1;
            end
          end
        end
        S_OPR2: begin
          if (rd_done) begin
            inst_hi_nxt    = mem_rdata;
            pc_nxt         = pc_inc;
            state_nxt      = S_HOLD;
            mem_rd_nxt     = 1'b0;
            inst_valid_nxt = 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            state_nxt      = S_OP;
            inst_valid_nxt = 1'b0;
            mem_rd_nxt     = 1'b1;
            mem_addr_nxt   = pc;
          end
        end
        default: begin
          state_nxt = S_VLO;
        end
      endcase
    end
  end

  // State, PC and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_VLO;
      pc         <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      inst_valid <= 1'b0;
      inst_op    <= 8'h00;
      inst_lo    <= 8'h00;
      inst_hi    <= 8'h00;
      inst_len   <= 2'd0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_rd     <= mem_rd_nxt;
      inst_valid <= inst_valid_nxt;
      inst_op    <= inst_op_nxt;
      inst_lo    <= inst_lo_nxt;
      inst_hi    <= inst_hi_nxt;
      inst_len   <= inst_len_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

`ifdef OPCODE_FETCH_PERF_EN
  // Free-running cycle count and accepted-bundle count, both wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= 32'd0;
      perf_insts  <= 32'd0;
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (inst_valid && inst_ready) perf_insts <= perf_insts + 32'd1;
    end
  end
`endif

endmodule
